// File: rtl/rggen_rtl_pkg.sv
// Shared rggen types used by the bus adapters.
//   rggen_direction : transfer direction carried on rggen_bus_if
//   rggen_status    : response status returned on rggen_bus_if
//   RGGEN_APB_PPROT_DEFAULT : default PPROT value for the APB bridge
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    localparam logic [2:0] RGGEN_APB_PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rggen_bus_if.sv
// Generic rggen register bus.
//   master modport : drives request/address/direction/write_data/write_strobe,
//                    receives done/read_data/status
//   slave modport  : the mirror image
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);

    logic                       request;
    logic [ADDRESS_WIDTH-1:0]   address;
    rggen_direction             direction;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     write_strobe;
    logic                       done;
    logic [BUS_WIDTH-1:0]       read_data;
    rggen_status                status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_data, status
    );

endinterface

// File: rtl/rggen_apb_bridge.sv
// Converts one rggen_bus_if transaction into one APB4 transfer.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus_if (slave)    : request side from the external-register block
//   psel..pstrb       : APB4 master outputs, all derived from flops
//   pready/prdata/pslverr : APB4 slave response
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | no transfer; APB outputs parked at zero
// SETUP  | psel=1, penable=0; request fields already latched
// ACCESS | psel=1, penable=1; held until pready
module rggen_apb_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int         ADDRESS_WIDTH     = 16,
    parameter int         DATA_WIDTH        = 32,
    parameter int         APB_ADDRESS_WIDTH = 16,
    parameter logic [2:0] PPROT_VALUE       = RGGEN_APB_PPROT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rggen_bus_if.slave                   bus_if,
    output logic                         psel,
    output logic                         penable,
    output logic [APB_ADDRESS_WIDTH-1:0] paddr,
    output logic [2:0]                   pprot,
    output logic                         pwrite,
    output logic [DATA_WIDTH-1:0]        pwdata,
    output logic [DATA_WIDTH/8-1:0]      pstrb,
    input  logic                         pready,
    input  logic [DATA_WIDTH-1:0]        prdata,
    input  logic                         pslverr
);

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_data_width
        $error("rggen_apb_bridge: DATA_WIDTH must be 8, 16 or 32");
    end
    if (APB_ADDRESS_WIDTH < ADDRESS_WIDTH) begin : g_bad_addr_width
        $error("rggen_apb_bridge: APB_ADDRESS_WIDTH must be >= ADDRESS_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_e;

    state_e                      state_q,   state_d;
    logic [ADDRESS_WIDTH-1:0]    address_q, address_d;
    logic                        write_q,   write_d;
    logic [DATA_WIDTH-1:0]       wdata_q,   wdata_d;
    logic [DATA_WIDTH/8-1:0]     strobe_q,  strobe_d;

    logic active;
    logic done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            address_q <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strobe_q  <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strobe_q  <= strobe_d;
        end
    end

    // Request fields are captured only when leaving IDLE, so upstream may
    // drop or change them mid-transfer without disturbing the APB side.
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strobe_d  = strobe_q;
        case (state_q)
            IDLE: begin
                if (bus_if.request) begin
                    state_d   = SETUP;
                    address_d = bus_if.address;
                    write_d   = (bus_if.direction == RGGEN_WRITE);
                    wdata_d   = bus_if.write_data;
                    strobe_d  = bus_if.write_strobe;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign active = (state_q != IDLE);
    assign done   = (state_q == ACCESS) && pready;

    // APB outputs decode only flops; reads force pwdata/pstrb to zero.
    assign psel    = active;
    assign penable = (state_q == ACCESS);
    assign paddr   = active ? APB_ADDRESS_WIDTH'(address_q) : '0;
    assign pprot   = PPROT_VALUE;
    assign pwrite  = active && write_q;
    assign pwdata  = (active && write_q) ? wdata_q  : '0;
    assign pstrb   = (active && write_q) ? strobe_q : '0;

    assign bus_if.done      = done;
    assign bus_if.read_data = (done && !write_q) ? prdata : '0;
    assign bus_if.status    = (done && pslverr) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
module tb_rggen_apb_bridge;
    import rggen_rtl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bus_if ();

    rggen_apb_bridge #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .APB_ADDRESS_WIDTH(16), .PPROT_VALUE(3'b000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_if(bus_if),
        .psel(psel), .penable(penable), .paddr(paddr), .pprot(pprot),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic        drop_req;
        logic [31:0] exp_rdata;
        rggen_status exp_status;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered #1 after a posedge; returns #1 after the posedge that follows done.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        string       tag;
        tag        = $sformatf("v%0d", idx);
        exp_pwdata = v.write ? v.wdata : 32'h0;
        exp_pstrb  = v.write ? v.strb  : 4'h0;

        bus_if.request      = 1'b1;
        bus_if.address      = v.addr;
        bus_if.direction    = v.write ? RGGEN_WRITE : RGGEN_READ;
        bus_if.write_data   = v.wdata;
        bus_if.write_strobe = v.strb;

        @(negedge clk);
        chk({tag, " idle psel"},   32'(psel), 32'h0);
        chk({tag, " idle paddr"},  32'(paddr), 32'h0);
        chk({tag, " idle done"},   32'(bus_if.done), 32'h0);
        chk({tag, " idle status"}, 32'(bus_if.status), 32'(RGGEN_OKAY));

        @(posedge clk); #1;
        if (v.drop_req) begin
            bus_if.request    = 1'b0;
            bus_if.address    = ~v.addr;
            bus_if.write_data = ~v.wdata;
        end
        @(negedge clk);
        chk({tag, " setup psel"},    32'(psel), 32'h1);
        chk({tag, " setup penable"}, 32'(penable), 32'h0);
        chk({tag, " setup paddr"},   32'(paddr), 32'(v.addr));
        chk({tag, " setup pwrite"},  32'(pwrite), 32'(v.write));
        chk({tag, " setup pwdata"},  pwdata, exp_pwdata);
        chk({tag, " setup pstrb"},   32'(pstrb), 32'(exp_pstrb));
        chk({tag, " setup pprot"},   32'(pprot), 32'h0);
        chk({tag, " setup done"},    32'(bus_if.done), 32'h0);

        for (int k = 0; k <= v.waits; k++) begin
            @(posedge clk); #1;
            pready  = (k == v.waits);
            prdata  = v.prdata;
            pslverr = v.slverr;
            @(negedge clk);
            chk({tag, " acc psel"},    32'(psel), 32'h1);
            chk({tag, " acc penable"}, 32'(penable), 32'h1);
            chk({tag, " acc paddr"},   32'(paddr), 32'(v.addr));
            chk({tag, " acc pwrite"},  32'(pwrite), 32'(v.write));
            chk({tag, " acc pwdata"},  pwdata, exp_pwdata);
            chk({tag, " acc pstrb"},   32'(pstrb), 32'(exp_pstrb));
            chk({tag, " acc done"},    32'(bus_if.done), (k == v.waits) ? 32'h1 : 32'h0);
            chk({tag, " acc rdata"},   bus_if.read_data, (k == v.waits) ? v.exp_rdata : 32'h0);
            chk({tag, " acc status"},  32'(bus_if.status),
                (k == v.waits) ? 32'(v.exp_status) : 32'(RGGEN_OKAY));
        end

        @(posedge clk); #1;
        bus_if.request = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
    endtask

    logic mon_en = 1'b0;
    int   done_seen = 0;
    always @(negedge clk) if (mon_en && bus_if.done) done_seen++;

    initial begin
        vec_t rv;
        //          wr    addr      wdata         strb  w  prdata        err   drop  exp_rdata     exp_status
        vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h11111111, 1'b0, 1'b0, 32'h00000000, RGGEN_OKAY};
        vecs[1] = '{1'b0, 16'h0004, 32'h00000000, 4'h0, 3, 32'h12345678, 1'b0, 1'b0, 32'h12345678, RGGEN_OKAY};
        vecs[2] = '{1'b1, 16'h0020, 32'h0BADF00D, 4'hF, 0, 32'h22222222, 1'b1, 1'b0, 32'h00000000, RGGEN_SLAVE_ERROR};
        vecs[3] = '{1'b1, 16'h0030, 32'hAABBCCDD, 4'h5, 1, 32'h33333333, 1'b0, 1'b0, 32'h00000000, RGGEN_OKAY};
        vecs[4] = '{1'b0, 16'h0034, 32'h99999999, 4'hA, 0, 32'h55AA55AA, 1'b0, 1'b1, 32'h55AA55AA, RGGEN_OKAY};
        vecs[5] = '{1'b0, 16'hFFFC, 32'h00000000, 4'h0, 2, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, RGGEN_SLAVE_ERROR};

        bus_if.request      = 1'b0;
        bus_if.address      = '0;
        bus_if.direction    = RGGEN_READ;
        bus_if.write_data   = '0;
        bus_if.write_strobe = '0;

        repeat (2) @(negedge clk);
        chk("rst psel",    32'(psel), 32'h0);
        chk("rst penable", 32'(penable), 32'h0);
        chk("rst paddr",   32'(paddr), 32'h0);
        chk("rst pwrite",  32'(pwrite), 32'h0);
        chk("rst pwdata",  pwdata, 32'h0);
        chk("rst pstrb",   32'(pstrb), 32'h0);
        chk("rst done",    32'(bus_if.done), 32'h0);
        chk("rst rdata",   bus_if.read_data, 32'h0);
        chk("rst status",  32'(bus_if.status), 32'(RGGEN_OKAY));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vectors run back to back: each new request rises the cycle after done.
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        mon_en = 1'b0;
        chk("b2b done pulses", 32'(done_seen), 32'd6);

        @(negedge clk);
        chk("post psel",   32'(psel), 32'h0);
        chk("post status", 32'(bus_if.status), 32'(RGGEN_OKAY));
        @(posedge clk); #1;

        // Reset in the middle of an ACCESS wait state.
        done_seen = 0;
        mon_en = 1'b1;
        bus_if.request   = 1'b1;
        bus_if.address   = 16'h0008;
        bus_if.direction = RGGEN_READ;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pready = 1'b0;
        prdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("mid penable before rst", 32'(penable), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst psel",    32'(psel), 32'h0);
        chk("mid rst penable", 32'(penable), 32'h0);
        chk("mid rst paddr",   32'(paddr), 32'h0);
        chk("mid rst done",    32'(bus_if.done), 32'h0);
        bus_if.request = 1'b0;
        pready = 1'b1;
        repeat (2) @(negedge clk);
        chk("in rst psel", 32'(psel), 32'h0);
        rst_n = 1'b1;
        pready = 1'b0;
        prdata = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("after rst psel", 32'(psel), 32'h0);
        mon_en = 1'b0;
        chk("mid rst no done", 32'(done_seen), 32'd0);
        @(posedge clk); #1;

        rv = '{1'b0, 16'h0008, 32'h0, 4'h0, 1, 32'h0F0F1234, 1'b0, 1'b0, 32'h0F0F1234, RGGEN_OKAY};
        run_vec(rv, 6);
        @(negedge clk);
        chk("final psel", 32'(psel), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
